// File: rtl/dm_pkg.sv
// Shared DataMem pointer-table definitions: widths, temp-slot base, lookup FSM states.
package dm_pkg;

    localparam int PTR_W        = 3;
    localparam int ADDR_W       = 10;
    localparam int DM_TEMP_BASE = 64;
    localparam int DEPTH        = 2 ** PTR_W;

    typedef logic [PTR_W-1:0]  ptr_t;
    typedef logic [ADDR_W-1:0] dm_addr_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } lk_state_t;

    // Reset address of temp slot idx, truncated to the DataMem address width.
    function automatic dm_addr_t temp_addr(input int unsigned idx);
        return dm_addr_t'(DM_TEMP_BASE + idx);
    endfunction

endpackage

// File: rtl/dm_ptr_table_if.sv
// Bus bundle for the pointer table: forward lookup, writer port, reverse-lookup handshake.
interface dm_ptr_table_if;
    import dm_pkg::*;

    ptr_t     ptr;
    dm_addr_t target;
    logic     wr_en;
    ptr_t     wr_ptr;
    dm_addr_t wr_addr;
    logic     lk_req;
    dm_addr_t lk_addr;
    logic     lk_busy;
    logic     lk_done;
    logic     lk_hit;
    ptr_t     lk_ptr;

    modport master (
        output ptr, wr_en, wr_ptr, wr_addr, lk_req, lk_addr,
        input  target, lk_busy, lk_done, lk_hit, lk_ptr
    );

    modport slave (
        input  ptr, wr_en, wr_ptr, wr_addr, lk_req, lk_addr,
        output target, lk_busy, lk_done, lk_hit, lk_ptr
    );

endinterface

// File: rtl/dm_ptr_table.sv
// Programmable pointer table for the DataMem temp region with combinational forward
// lookup and a sequential ascending-scan reverse lookup (address -> lowest pointer).
module dm_ptr_table
    import dm_pkg::*;
(
    input  logic           clk,
    input  logic           reset_n,
    dm_ptr_table_if.slave  bus
);

    localparam ptr_t LAST_IDX = {PTR_W{1'b1}};

    if (DM_TEMP_BASE + DEPTH > 2 ** ADDR_W) begin : g_base_range_bad
        $error("dm_ptr_table: temp region exceeds DataMem address space");
    end

    dm_addr_t  table_r [DEPTH];
    lk_state_t state_r, state_s;
    ptr_t      idx_r, idx_s;
    dm_addr_t  key_r, key_s;
    logic      hit_r, hit_s;
    ptr_t      lkptr_r, lkptr_s;
    logic      busy_r, done_r;

    // Forward lookup: no bypass, a write shows up after its edge.
    assign bus.target  = table_r[bus.ptr];
    assign bus.lk_busy = busy_r;
    assign bus.lk_done = done_r;
    assign bus.lk_hit  = hit_r;
    assign bus.lk_ptr  = lkptr_r;

    // Table storage: reset to the standard temp slots, retargeted by the writer port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_r[i] <= temp_addr(i);
            end
        end else if (bus.wr_en) begin
            table_r[bus.wr_ptr] <= bus.wr_addr;
        end
    end

    // Reverse-lookup state, scan index, key and result registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            idx_r   <= '0;
            key_r   <= '0;
            hit_r   <= 1'b0;
            lkptr_r <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            key_r   <= key_s;
            hit_r   <= hit_s;
            lkptr_r <= lkptr_s;
            busy_r  <= (state_s != IDLE);
            done_r  <= (state_s == DONE);
        end
    end

    // Next-state logic; the compare sees the table value present before any same-edge write.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        key_s   = key_r;
        hit_s   = hit_r;
        lkptr_s = lkptr_r;
        case (state_r)
            IDLE: begin
                if (bus.lk_req) begin
                    key_s   = bus.lk_addr;
                    idx_s   = '0;
                    hit_s   = 1'b0;
                    lkptr_s = '0;
                    state_s = SCAN;
                end else begin
                    state_s = IDLE;
                end
            end
            SCAN: begin
                if (table_r[idx_r] == key_r) begin
                    hit_s   = 1'b1;
                    lkptr_s = idx_r;
                    state_s = DONE;
                end else if (idx_r == LAST_IDX) begin
                    hit_s   = 1'b0;
                    lkptr_s = '0;
                    state_s = DONE;
                end else begin
                    idx_s   = idx_r + ptr_t'(1);
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dm_ptr_table.sv
// Scoreboard bench for dm_ptr_table: forward sweeps against a table model and
// reverse lookups checked for result and completion cycle.
module tb_dm_ptr_table;
    import dm_pkg::*;

    typedef struct {
        logic hit;
        ptr_t ptr;
        int   done_cyc;
    } exp_t;

    logic clk;
    logic reset_n;
    dm_ptr_table_if bus ();

    dm_ptr_table dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int       chk_cnt;
    int       pass_cnt;
    int       cycle_cnt;
    exp_t     sb [$];
    dm_addr_t model_tbl [DEPTH];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Completion monitor: every LkDone must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset_n && bus.lk_done === 1'b1) begin
            if (sb.size() == 0) begin
                check_eq("spurious_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq("lk_hit", 32'(bus.lk_hit), 32'(e.hit));
                check_eq("lk_ptr", 32'(bus.lk_ptr), 32'(e.ptr));
                check_eq("done_cycle", 32'(cycle_cnt), 32'(e.done_cyc));
                check_eq("busy_in_done", 32'(bus.lk_busy), 32'd1);
            end
        end
    end

    task automatic sweep_targets(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            bus.ptr = ptr_t'(i);
            #1;
            check_eq(tag, 32'(bus.target), 32'(model_tbl[i]));
        end
    endtask

    task automatic write_entry(input ptr_t p, input dm_addr_t a);
        bus.wr_en   = 1'b1;
        bus.wr_ptr  = p;
        bus.wr_addr = a;
        @(posedge clk);
        #1;
        bus.wr_en   = 1'b0;
        model_tbl[p] = a;
    endtask

    // Drive a request; the next edge is the accept edge E0. Latency: hit at i -> E(i+1), miss -> E(DEPTH).
    task automatic start_lookup(input dm_addr_t a, input logic hit, input ptr_t p, output int c0);
        exp_t e;
        bus.lk_req  = 1'b1;
        bus.lk_addr = a;
        @(posedge clk);
        #1;
        c0 = cycle_cnt;
        bus.lk_req = 1'b0;
        e.hit      = hit;
        e.ptr      = hit ? p : ptr_t'(0);
        e.done_cyc = c0 + (hit ? int'(p) + 1 : DEPTH);
        sb.push_back(e);
    endtask

    task automatic wait_done();
        for (int k = 0; k < 40 && sb.size() > 0; k++) @(posedge clk);
        if (sb.size() > 0) begin
            check_eq("done_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        #1;
        check_eq("busy_clear", 32'(bus.lk_busy), 32'd0);
    endtask

    task automatic lookup(input dm_addr_t a, input logic hit, input ptr_t p);
        int c0;
        start_lookup(a, hit, p, c0);
        wait_done();
    endtask

    initial begin
        int   c0;
        exp_t e;
        chk_cnt   = 0;
        pass_cnt  = 0;
        cycle_cnt = 0;
        reset_n   = 1'b0;
        bus.ptr = '0; bus.wr_en = 1'b0; bus.wr_ptr = '0; bus.wr_addr = '0;
        bus.lk_req = 1'b0; bus.lk_addr = '0;
        for (int i = 0; i < DEPTH; i++) model_tbl[i] = dm_addr_t'(64 + i);

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check_eq("rst_busy", 32'(bus.lk_busy), 32'd0);
        check_eq("rst_done", 32'(bus.lk_done), 32'd0);
        check_eq("rst_hit",  32'(bus.lk_hit),  32'd0);
        check_eq("rst_ptr",  32'(bus.lk_ptr),  32'd0);
        sweep_targets("rst_target");

        lookup(dm_addr_t'(67), 1'b1, ptr_t'(3));
        check_eq("hold_hit", 32'(bus.lk_hit), 32'd1);
        check_eq("hold_ptr", 32'(bus.lk_ptr), 32'd3);

        // Miss with the request held high: the second accept lands on the first idle edge.
        bus.lk_req  = 1'b1;
        bus.lk_addr = dm_addr_t'(100);
        @(posedge clk);
        #1;
        c0 = cycle_cnt;
        e.hit = 1'b0; e.ptr = '0; e.done_cyc = c0 + DEPTH;
        sb.push_back(e);
        bus.lk_addr = dm_addr_t'(67);
        e.hit = 1'b1; e.ptr = ptr_t'(3); e.done_cyc = c0 + DEPTH + 2 + 4;
        sb.push_back(e);
        while (cycle_cnt < c0 + DEPTH + 2) @(posedge clk);
        #1;
        bus.lk_req = 1'b0;
        wait_done();

        write_entry(ptr_t'(5), dm_addr_t'(200));
        bus.ptr = ptr_t'(5);
        #1;
        check_eq("fwd_after_write", 32'(bus.target), 32'd200);
        lookup(dm_addr_t'(200), 1'b1, ptr_t'(5));
        lookup(dm_addr_t'(69),  1'b0, ptr_t'(0));

        write_entry(ptr_t'(6), dm_addr_t'(65));
        lookup(dm_addr_t'(65), 1'b1, ptr_t'(1));
        sweep_targets("wr_target");

        start_lookup(dm_addr_t'(300), 1'b1, ptr_t'(7), c0);
        write_entry(ptr_t'(7), dm_addr_t'(300));
        wait_done();

        // Reset mid-scan at idx 4: outputs and table restore, the aborted lookup never completes.
        start_lookup(dm_addr_t'(999), 1'b0, ptr_t'(0), c0);
        repeat (4) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        sb.delete();
        for (int i = 0; i < DEPTH; i++) model_tbl[i] = dm_addr_t'(64 + i);
        check_eq("abort_busy", 32'(bus.lk_busy), 32'd0);
        check_eq("abort_done", 32'(bus.lk_done), 32'd0);
        check_eq("abort_hit",  32'(bus.lk_hit),  32'd0);
        check_eq("abort_ptr",  32'(bus.lk_ptr),  32'd0);
        sweep_targets("abort_target");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check_eq("post_abort_busy", 32'(bus.lk_busy), 32'd0);
        lookup(dm_addr_t'(71), 1'b1, ptr_t'(7));

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/dm_ptr_table.md
# dm_ptr_table

Programmable, bidirectional pointer table for the DataMem temporary-variable region. Keeps 2^PTR_W entries of DataMem addresses, resetting to the standard temp slots BASE..BASE+7 (64..71). Provides the forward lookup (pointer → address) combinationally for the load/store path. Provides a writer port for the loader or control unit to retarget entries. Provides a multi-cycle reverse lookup (address → pointer) FSM used by the assembler-support/debug path to find which short pointer reaches a given DataMem address.

## Interface
- PTR_W, 3: pointer width; table depth is 2^PTR_W
- ADDR_W, 10: DataMem address width
- BASE, 64: reset address of entry 0; entry i resets to BASE+i
- Clk  in  1  rising-edge clock
- Reset_n  in  1  asynchronous, active-low reset
- Ptr  in  PTR_W  forward lookup index
- Target  out  ADDR_W  table[Ptr], combinational
- WrEn  in  1  write strobe
- WrPtr  in  PTR_W  entry to write
- WrAddr  in  ADDR_W  new address for entry
- LkReq  in  1  reverse-lookup request, sampled only when idle
- LkAddr  in  ADDR_W  address to search for, latched on accept
- LkBusy  out  1  high while the FSM is not IDLE
- LkDone  out  1  one-cycle completion pulse
- LkHit  out  1  result: match found
- LkPtr  out  PTR_W  result: lowest matching index (0 on miss)

## Operation
- Reset (async assert, sync-safe deassert by system): table[i]=BASE+i; state IDLE; scan index 0; LkBusy=0, LkDone=0, LkHit=0, LkPtr=0.
- Write: WrEn high at an edge → table[WrPtr]=WrAddr after that edge. Target reflects the new value in the cycle after the edge; no same-cycle bypass.
- FSM states are IDLE, SCAN, and DONE.
- IDLE: if LkReq=1, latch LkAddr into KeyReg, set idx=0, clear LkHit/LkPtr, go to SCAN.
- SCAN: compare table[idx] with KeyReg.
  - On a match, set LkHit=1 and LkPtr=idx, then go to DONE.
  - Otherwise, if idx=2^PTR_W−1, set LkHit=0 and LkPtr=0, then go to DONE.
  - Otherwise, increment idx.
- DONE: LkDone=1 for this single cycle, then go to IDLE.
- LkReq is ignored in SCAN and DONE; no queueing.
- Duplicate entries: the lowest index wins, which falls out of the ascending scan.
- Write colliding with scan: comparison at an edge uses the pre-write value. An entry written before the scan reaches it is seen with its new value.
- LkHit/LkPtr hold their value until the next accepted request.
- Width rule: BASE+i is computed in ADDR_W bits. The elaboration check requires BASE+2^PTR_W ≤ 2^ADDR_W.

## Timing
- Target: zero latency, purely combinational from Ptr and table registers.
- Reverse lookup, request accepted at edge E0:
  - Entry i is compared at edge E(i+1).
  - A hit at index i gives LkDone in the cycle after E(i+1), with LkHit/LkPtr valid in the same cycle.
  - A miss gives LkDone in the cycle after E(2^PTR_W), i.e. after E8 by default.
- LkBusy is high from the cycle after E0 through the DONE cycle inclusive.
- A new request is accepted no earlier than the first IDLE cycle after DONE.
- Minimum request-to-request spacing: i+3 cycles on a hit at i; 2^PTR_W+2 cycles on a miss.
- Reset_n low mid-scan immediately returns to reset state: table restored, LkDone is never emitted for the aborted request.

## Structure
- Shared package dm_pkg holds:
  - PTR_W, ADDR_W, DM_TEMP_BASE constants
  - typedef enum logic [1:0] {IDLE, SCAN, DONE} lk_state_t
  - typedefs ptr_t and dm_addr_t
- Single module, no sub-module: a table register array, write logic, and the reverse-lookup FSM with idx counter and KeyReg.

## Test plan
- Reset, then sweep Ptr 0..7 → Target = 64..71; LkBusy=0, LkDone=0, LkHit=0, LkPtr=0.
- LkReq with LkAddr=67 in idle → LkHit=1, LkPtr=3, LkDone pulses one cycle after the 4th post-accept edge; LkBusy deasserts next cycle.
- LkAddr=100 → LkHit=0, LkPtr=0, LkDone after the 8th post-accept edge. A second LkReq held high throughout is accepted only after DONE.
- Write WrPtr=5, WrAddr=200; next cycle Ptr=5 → Target=200. Lookup 200 → hit, LkPtr=5. Lookup 69 → miss.
- Write WrPtr=6, WrAddr=65, then lookup 65 → LkPtr=1 (lowest index wins). Separately, during a scan for 300, write entry 7=300 while idx<7 → hit, LkPtr=7.
- Assert Reset_n low during SCAN at idx=4 → all outputs return to 0 and table to 64..71 asynchronously; no LkDone pulse after release.
